// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared CPU parameters for the multiply/divide unit.
// Holds the MDOp operation encodings, default latencies and small op-class
// helpers used by mult_div_unit and md_alu.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu). When it is
// undefined those four codes decode as NONE.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_div_op(logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul_op(logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) ||
         (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  // Ops that occupy the unit for a multi-cycle run.
  function automatic logic is_start_op(logic [3:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_alu.sv
// md_alu: combinational datapath of the multiply/divide unit.
// Ports:
//   op       in  4   latched operation code
//   a, b     in  32  latched operands (Rs, Rt)
//   hilo     in  64  current {HI,LO}, accumulator source and hold value
//   result   out 64  new {HI,LO}
//   div_zero out 1   divide op with zero divisor; caller must not write HI/LO
// Optional feature macro: MDU_MADD_EN adds the accumulate/subtract adder.
module md_alu
  import mult_div_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo,
  output logic [63:0] result,
  output logic        div_zero
);

  logic        mul_signed;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;

  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] divisor;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quot;
  logic [31:0] rem;

  // One 64x64 multiplier serves both signednesses via operand extension.
  always_comb begin
    mul_signed = (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
    ext_a      = {{32{mul_signed & a[31]}}, a};
    ext_b      = {{32{mul_signed & b[31]}}, b};
    product    = ext_a * ext_b;
  end

  // Signed divide runs on magnitudes; this also yields 0x80000000 / -1 =
  // 0x80000000 rem 0 without a special case.
  always_comb begin
    div_signed = (op == MD_DIV);
    a_neg      = div_signed & a[31];
    b_neg      = div_signed & b[31];
    abs_a      = a_neg ? (~a + 32'd1) : a;
    abs_b      = b_neg ? (~b + 32'd1) : b;
    divisor    = (b == 32'd0) ? 32'd1 : abs_b;
    q_u        = abs_a / divisor;
    r_u        = abs_a % divisor;
    quot       = (a_neg ^ b_neg) ? (~q_u + 32'd1) : q_u;
    rem        = a_neg ? (~r_u + 32'd1) : r_u;
  end

  always_comb begin
    result   = hilo;
    div_zero = is_div_op(op) && (b == 32'd0);
    case (op)
      MD_MULT, MD_MULTU: result = product;
      MD_DIV, MD_DIVU:   result = {rem, quot};
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: result = hilo + product;
      MD_MSUB, MD_MSUBU: result = hilo - product;
`endif
      default:           result = hilo;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: EX-stage multiply/divide unit with HI/LO registers.
// Accepts a one-cycle Start pulse, runs a fixed-latency operation on latched
// operands and writes HI/LO on the edge at which Busy falls. mthi/mtlo write
// HI/LO directly when idle.
// Ports:
//   clk    in  1   clock
//   reset  in  1   synchronous active-high reset
//   Start  in  1   start pulse for mult/div (and madd family)
//   MDOp   in  4   operation code (mult_div_unit_pkg encodings)
//   In0    in  32  forwarded Rs
//   In1    in  32  forwarded Rt
//   Flush  in  1   suppresses a start or mthi/mtlo in this cycle
//   Busy   out 1   operation in progress
//   HI     out 32  HI register
//   LO     out 32  LO register
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu).
//
// state | meaning
// IDLE  | ready; accepts Start or mthi/mtlo
// RUN   | operation in flight, counter counting down to 0
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] In0,
  input  logic [31:0] In1,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [31:0]       hi_q;
  logic [31:0]       lo_q;

  logic              start_ok;
  logic              finish;
  logic              mthi_wr;
  logic              mtlo_wr;
  logic              hilo_wr;
  logic [63:0]       alu_result;
  logic              alu_div_zero;

  md_alu u_md_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hilo     ({hi_q, lo_q}),
    .result   (alu_result),
    .div_zero (alu_div_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_ok = 1'b0;
    finish   = 1'b0;
    mthi_wr  = 1'b0;
    mtlo_wr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!Flush) begin
          if (Start && is_start_op(MDOp)) begin
            start_ok = 1'b1;
            state_d  = S_RUN;
            cnt_d    = is_div_op(MDOp) ? DIV_LOAD : MULT_LOAD;
          end else if (MDOp == MD_MTHI) begin
            mthi_wr = 1'b1;
          end else if (MDOp == MD_MTLO) begin
            mtlo_wr = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Flush is deliberately ignored here: the op is past its exception point.
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divide by zero still spends the full run but leaves HI/LO alone.
  assign hilo_wr = finish && !alu_div_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start_ok) begin
        op_q <= MDOp;
        a_q  <= In0;
        b_q  <= In1;
      end
      if (hilo_wr) begin
        hi_q <= alu_result[63:32];
        lo_q <= alu_result[31:0];
      end else if (mthi_wr) begin
        hi_q <= In0;
      end else if (mtlo_wr) begin
        lo_q <= In0;
      end
    end
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit on the consuming end of the decode stage's mult/div start interface. It sits in EX and accepts operations pulsed by `Start` with the already-forwarded operands. It runs them over a fixed multi-cycle latency and holds the HI/LO results. Its `Busy` output feeds the stall logic, which holds mult-type instructions in ID.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu (and madd family when enabled)
- `DIV_CYCLES`, 10: busy cycles for div/divu

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `Start`  in  1  one-cycle pulse: mult/multu/div/divu (and madd family) presented this cycle
- `MDOp`  in  4  operation code (package encodings), valid with `Start` or for mthi/mtlo
- `In0`  in  32  forwarded Rs value
- `In1`  in  32  forwarded Rt value
- `Flush`  in  1  exception/interrupt in this cycle; suppresses any start or HI/LO write
- `Busy`  out  1  operation in progress
- `HI`  out  32  HI register
- `LO`  out  32  LO register

## Operation
- Reset values: `Busy`=0, `HI`=0, `LO`=0, internal counter=0, latched operands=0.
- States:
  - IDLE: `Busy`=0.
  - RUN: `Busy`=1, counter counts down.
- IDLE with `Start`=1, `Flush`=0, and a mult/div op:
  - latch `In0`, `In1`, `MDOp`
  - load counter with N−1 (N=MULT_CYCLES or DIV_CYCLES)
  - go to RUN.
- RUN with counter≠0: decrement.
- RUN with counter=0:
  - write HI/LO from the result computed on the latched operands
  - go to IDLE.
- mthi/mtlo in IDLE with `Flush`=0: write `In0` to HI/LO at that edge. No busy time.
- Ignored inputs:
  - `Start` or mthi/mtlo while in RUN is ignored. Stall logic guarantees this never happens, but the unit must not corrupt state if it does.
  - `Flush`=1 during RUN does not abort; the instruction has already passed its exception point.
  - `MDOp`=NONE or an unknown code: no effect.
- Arithmetic:
  - mult: signed 32×32→64.
  - multu: unsigned 32×32→64.
  - HI=product[63:32], LO=product[31:0].
  - div: signed, quotient truncated toward zero, remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - divu: unsigned.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0: full DIV_CYCLES busy, HI/LO unchanged.

## Timing
- `Start` is sampled at edge E0. `Busy` is 1 for exactly N cycles, E0 through E_N.
- HI/LO update at E_N, the same edge at which `Busy` falls.
- The next `Start` is accepted at E_N+1 at the earliest. A `Start` at E_N itself is ignored.
- mthi/mtlo: HI/LO reflect `In0` one edge after issue.
- `HI`/`LO` are register outputs, with no combinational path from inputs.
- `reset` at any edge, including mid-RUN: immediately return to the reset values and drop the pending result.

## Configuration
- `MDU_MADD_EN` defined:
  - adds madd, maddu, msub, msubu.
  - {HI,LO} ← {HI,LO} ± product (signed/unsigned), 64-bit wrap-around.
  - MULT_CYCLES latency.
  - {HI,LO} is sampled at E_N, not at Start.
- `MDU_MADD_EN` undefined:
  - those codes decode as NONE.
  - no accumulator adder is synthesized.

## Structure
- Shared package (`CPU_Param` family) holds:
  - `MDOp` encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10
  - default latency constants.
- One natural sub-module, `md_alu`: combinational, takes the latched operands, op, and current {HI,LO}, and returns the 64-bit result plus a divide-by-zero flag.
- The counter/FSM and the HI/LO registers stay in `mult_div_unit`.

## Test plan
- mult 0xFFFFFFFE × 3 (signed) -> `Busy` high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA at falling edge of `Busy`. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div −7 / 2 -> `Busy` 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7 / 0 -> 10 busy cycles, HI/LO keep prior values.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles -> HI/LO updated one edge after each, `Busy` stays 0. mthi issued during RUN -> HI unchanged.
- `Start` with `Flush`=1 -> `Busy` stays 0, HI/LO unchanged. `Flush` pulsed in the 3rd busy cycle of a mult -> result still written.
- `reset` asserted in the 4th cycle of a div -> next cycle `Busy`=0, HI=LO=0. A new mult then completes normally.
- With `MDU_MADD_EN`: HI:LO=0x0:0xFFFFFFFF, then maddu 1×1 -> HI=0x00000001, LO=0x00000000. Without the macro, the same op code leaves HI/LO unchanged and `Busy` stays 0.
